// File: rtl/tgl_hs_rx.sv
// tgl_hs_rx -- responder end of a two-phase (toggle) request/acknowledge link.
//
// The initiator drives req_tgl from a toggle flop and holds req_data steady
// until it sees ack_tgl toggle. This block synchronizes req_tgl, detects each
// level change, and captures req_data into a small FIFO. It toggles ack_tgl
// once for every word accepted into the FIFO. A local valid/ready consumer
// drains the FIFO.
//
// Ports:
//   clk        in   single clock, rising edge
//   clr        in   synchronous active-high reset
//   req_tgl    in   request toggle, asynchronous to clk
//   req_data   in   [WIDTH] request word, stable until the matching ack
//   ack_tgl    out  acknowledge toggle, registered
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer takes the head word
//   out_data   out  [WIDTH] head-of-FIFO word, registered
//   fill       out  [$clog2(DEPTH)+1] occupied FIFO entries
//   err_sticky out  protocol-violation flag (only with TGL_HS_RX_ERR_EN)
//
// Optional build macro: TGL_HS_RX_ERR_EN adds err_sticky. The flag sets when
// a request toggle arrives while a request is already held, or when edges are
// seen on two consecutive cycles. The offending toggle is ignored.

module tgl_hs_rx #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    req_tgl,
    input  logic [WIDTH-1:0]        req_data,
    output logic                    ack_tgl,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH):0]  fill
`ifdef TGL_HS_RX_ERR_EN
    ,
    output logic                    err_sticky
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_d_q;
    logic                   req_edge;
    logic                   take_edge;
    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [WIDTH-1:0]       head_q, head_d;
    logic                   ack_q;
    logic                   valid_q;
    logic                   full;
    logic                   wr_en;
    logic                   pop;

    assign req_edge = sync_q[SYNC_STAGES-1] ^ req_d_q;
    assign full     = (fill_q == FW'(DEPTH));
    assign pop      = valid_q & out_ready;

`ifdef TGL_HS_RX_ERR_EN
    logic edge_prev_q;
    logic err_q;

    // An edge directly after another edge is a protocol violation and is dropped.
    assign take_edge = req_edge & ~edge_prev_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            edge_prev_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            edge_prev_q <= req_edge;
            if (req_edge && (state_q == HOLD || edge_prev_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_sticky = err_q;
`else
    assign take_edge = req_edge;
`endif

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_edge) begin
                    if (full) begin
                        state_d = HOLD;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                // req_data is still held by the initiator, since no ack was sent.
                if (!full) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wptr_d = wptr_q + PW'(wr_en);
        rptr_d = rptr_q + PW'(pop);
        fill_d = fill_q + FW'(wr_en) - FW'(pop);

        // The incoming word becomes the head when it lands on the next read slot.
        if (wr_en && (wptr_q == rptr_d)) begin
            head_d = req_data;
        end else begin
            head_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q  <= '0;
            req_d_q <= 1'b0;
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], req_tgl};
            req_d_q <= sync_q[SYNC_STAGES-1];
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
            ack_q   <= ack_q ^ wr_en;
            valid_q <= (fill_d != '0);
            head_q  <= head_d;
        end
    end

    // Storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem_q[wptr_q] <= req_data;
        end
    end

    assign ack_tgl   = ack_q;
    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_tgl_hs_rx.sv
module tb_tgl_hs_rx;
    localparam int WIDTH       = 8;
    localparam int DEPTH       = 2;
    localparam int SYNC_STAGES = 2;
    localparam int FW          = $clog2(DEPTH) + 1;
    // Edges from the last edge before a req_tgl change to the acking edge.
    localparam int LAT         = SYNC_STAGES + 1;

    logic             clk       = 1'b0;
    logic             clr       = 1'b1;
    logic             req_tgl   = 1'b0;
    logic [WIDTH-1:0] req_data  = '0;
    logic             out_ready = 1'b0;
    logic             ack_tgl;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [FW-1:0]    fill;
`ifdef TGL_HS_RX_ERR_EN
    logic             err_sticky;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level bookkeeping: acks seen, words popped, popped data.
    int               acks = 0;
    int               pops = 0;
    logic             ack_last = 1'b0;
    logic [WIDTH-1:0] popq[$];

    always #5 clk = ~clk;

    tgl_hs_rx #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .clr(clr),
        .req_tgl(req_tgl),
        .req_data(req_data),
        .ack_tgl(ack_tgl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .fill(fill)
`ifdef TGL_HS_RX_ERR_EN
        ,
        .err_sticky(err_sticky)
`endif
    );

    // Advance one cycle from a falling edge to the next. A pop is recorded
    // from the values visible before the rising edge, and an ack toggle from
    // the values after it.
    task automatic tick();
        if (out_valid === 1'b1 && out_ready === 1'b1 && clr === 1'b0) begin
            popq.push_back(out_data);
            pops++;
        end
        @(negedge clk);
        if (ack_tgl !== ack_last) acks++;
        ack_last = ack_tgl;
    endtask

    task automatic clear_book();
        acks = 0;
        pops = 0;
        ack_last = 1'b0;
        popq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        req_tgl = 1'b0;
        req_data = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        clear_book();
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        req_data = w;
        req_tgl = ~req_tgl;
    endtask

    task automatic test_reset();
        do_reset();
        send(8'h3C);
        repeat (LAT + 1) tick();
        n_tests++;
        if (fill !== FW'(1)) begin n_fail++; $display("FAIL reset_pre_fill: got %0d want 1", fill); end
        clr = 1'b1;
        req_tgl = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ack_tgl !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_tgl); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++;
        if (fill !== '0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill); end
        n_tests++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
        clr = 1'b0;
        clear_book();
    endtask

    task automatic test_single();
        do_reset();
        send(8'hA5);
        tick();
        tick();
        n_tests++;
        if (ack_tgl !== 1'b0) begin n_fail++; $display("FAIL single_early_ack: got %b want 0", ack_tgl); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
        tick();
        n_tests++;
        if (ack_tgl !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b want 1", ack_tgl); end
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_tests++;
        if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", out_data); end
        n_tests++;
        if (fill !== FW'(1)) begin n_fail++; $display("FAIL single_fill: got %0d want 1", fill); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (fill !== '0) begin n_fail++; $display("FAIL single_pop_fill: got %0d want 0", fill); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_hold();
        int lat;
        do_reset();
        for (int w = 1; w <= 2; w++) begin
            send(WIDTH'(w));
            lat = 0;
            while (acks < w && lat < 10) begin tick(); lat++; end
            n_tests++;
            if (lat != LAT) begin n_fail++; $display("FAIL hold_ack_latency: got %0d want %0d", lat, LAT); end
        end
        send(8'h03);
        repeat (8) tick();
        n_tests++;
        if (acks != 2) begin n_fail++; $display("FAIL hold_no_ack: got %0d acks want 2", acks); end
        n_tests++;
        if (fill !== FW'(DEPTH)) begin n_fail++; $display("FAIL hold_full: got %0d want %0d", fill, DEPTH); end
        // Pop one word: the held write is blocked on the pop edge and lands one edge later.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (acks != 2) begin n_fail++; $display("FAIL hold_pop_edge_ack: got %0d acks want 2", acks); end
        n_tests++;
        if (fill !== FW'(DEPTH - 1)) begin n_fail++; $display("FAIL hold_pop_fill: got %0d want %0d", fill, DEPTH - 1); end
        tick();
        n_tests++;
        if (acks != 3) begin n_fail++; $display("FAIL hold_release_ack: got %0d acks want 3", acks); end
        n_tests++;
        if (fill !== FW'(DEPTH)) begin n_fail++; $display("FAIL hold_release_fill: got %0d want %0d", fill, DEPTH); end
        send(8'h04);
        repeat (8) tick();
        n_tests++;
        if (acks != 3) begin n_fail++; $display("FAIL hold_fourth_blocked: got %0d acks want 3", acks); end
        out_ready = 1'b1;
        repeat (12) tick();
        out_ready = 1'b0;
        n_tests++;
        if (acks != 4) begin n_fail++; $display("FAIL hold_total_acks: got %0d want 4", acks); end
        n_tests++;
        if (fill !== '0) begin n_fail++; $display("FAIL hold_drain_fill: got %0d want 0", fill); end
        n_tests++;
        if (popq.size() != 4) begin n_fail++; $display("FAIL hold_drain_count: got %0d want 4", popq.size()); end
        for (int i = 0; i < popq.size() && i < 4; i++) begin
            n_tests++;
            if (popq[i] !== WIDTH'(i + 1)) begin
                n_fail++; $display("FAIL hold_order[%0d]: got %h want %h", i, popq[i], i + 1);
            end
        end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] exp[$];
        logic [WIDTH-1:0] w;
        int lat;
        int maxfill;
        maxfill = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            w = WIDTH'($urandom);
            send(w);
            exp.push_back(w);
            lat = 0;
            while (acks == i && lat < 10) begin
                tick();
                lat++;
                if (int'(fill) > maxfill) maxfill = int'(fill);
            end
            n_tests++;
            if (lat != LAT) begin n_fail++; $display("FAIL stream_latency[%0d]: got %0d want %0d", i, lat, LAT); end
        end
        repeat (4) tick();
        out_ready = 1'b0;
        n_tests++;
        if (maxfill > 1) begin n_fail++; $display("FAIL stream_maxfill: got %0d want <=1", maxfill); end
        n_tests++;
        if (popq.size() != exp.size()) begin
            n_fail++; $display("FAIL stream_count: got %0d want %0d", popq.size(), exp.size());
        end
        for (int i = 0; i < popq.size() && i < exp.size(); i++) begin
            n_tests++;
            if (popq[i] !== exp[i]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, popq[i], exp[i]); end
        end
    endtask

    task automatic test_clr_hold();
        int lat;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(WIDTH'(8'hC0 + i));
            repeat (6) tick();
        end
        n_tests++;
        if (acks != 2) begin n_fail++; $display("FAIL clrhold_pre_acks: got %0d want 2", acks); end
        clr = 1'b1;
        req_tgl = 1'b0;
        @(negedge clk);
        n_tests++;
        if (fill !== '0) begin n_fail++; $display("FAIL clrhold_fill: got %0d want 0", fill); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clrhold_valid: got %b want 0", out_valid); end
        n_tests++;
        if (ack_tgl !== 1'b0) begin n_fail++; $display("FAIL clrhold_ack: got %b want 0", ack_tgl); end
        clr = 1'b0;
        clear_book();
        out_ready = 1'b1;
        repeat (8) tick();
        n_tests++;
        if (acks != 0) begin n_fail++; $display("FAIL clrhold_held_acked: got %0d acks want 0", acks); end
        n_tests++;
        if (fill !== '0) begin n_fail++; $display("FAIL clrhold_after_fill: got %0d want 0", fill); end
        send(8'h77);
        lat = 0;
        while (acks == 0 && lat < 10) begin tick(); lat++; end
        n_tests++;
        if (lat != LAT) begin n_fail++; $display("FAIL clrhold_idle_latency: got %0d want %0d", lat, LAT); end
        repeat (3) tick();
        out_ready = 1'b0;
        n_tests++;
        if (popq.size() != 1 || popq[0] !== 8'h77) begin
            n_fail++; $display("FAIL clrhold_new_word: got %0d words want one 77", popq.size());
        end
    endtask

    task automatic test_release_high();
        int lat;
        @(negedge clk);
        clr = 1'b1;
        req_tgl = 1'b1;
        req_data = 8'h5A;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        clear_book();
        lat = 0;
        while (acks == 0 && lat < 10) begin tick(); lat++; end
        n_tests++;
        if (lat != LAT) begin n_fail++; $display("FAIL release_latency: got %0d want %0d", lat, LAT); end
        n_tests++;
        if (ack_tgl !== 1'b1) begin n_fail++; $display("FAIL release_ack: got %b want 1", ack_tgl); end
        n_tests++;
        if (out_data !== 8'h5A) begin n_fail++; $display("FAIL release_data: got %h want 5a", out_data); end
        repeat (6) tick();
        n_tests++;
        if (acks != 1) begin n_fail++; $display("FAIL release_single: got %0d acks want 1", acks); end
        n_tests++;
        if (fill !== FW'(1)) begin n_fail++; $display("FAIL release_fill: got %0d want 1", fill); end
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic [WIDTH-1:0] exp[$];
        logic [WIDTH-1:0] w;
        int sent;
        int gap;
        int cyc;
        int occ;
        sent = 0;
        gap = 0;
        cyc = 0;
        do_reset();
        while ((sent < N || acks < N || acks != pops) && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (acks == sent && sent < N) begin
                if (gap == 0) begin
                    w = WIDTH'($urandom);
                    send(w);
                    exp.push_back(w);
                    sent++;
                    gap = $urandom_range(0, 3);
                end else begin
                    gap--;
                end
            end
            tick();
            cyc++;
            // Occupancy is every acked word not yet consumed.
            occ = acks - pops;
            n_tests++;
            if (int'(fill) != occ) begin n_fail++; $display("FAIL rand_fill@%0d: got %0d want %0d", cyc, fill, occ); end
            n_tests++;
            if (out_valid !== (occ != 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, out_valid, occ != 0); end
            n_tests++;
            if (acks > sent) begin n_fail++; $display("FAIL rand_extra_ack@%0d: got %0d acks want <=%0d", cyc, acks, sent); end
        end
        out_ready = 1'b0;
        n_tests++;
        if (cyc >= 3000) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles want <3000", cyc); end
        n_tests++;
        if (acks != N) begin n_fail++; $display("FAIL rand_acks: got %0d want %0d", acks, N); end
        n_tests++;
        if (popq.size() != exp.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", popq.size(), exp.size()); end
        for (int i = 0; i < popq.size() && i < exp.size(); i++) begin
            n_tests++;
            if (popq[i] !== exp[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, popq[i], exp[i]); end
        end
    endtask

`ifdef TGL_HS_RX_ERR_EN
    task automatic test_err();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(WIDTH'(8'h90 + i));
            repeat (6) tick();
        end
        n_tests++;
        if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b want 0", err_sticky); end
        req_tgl = ~req_tgl;
        repeat (4) tick();
        n_tests++;
        if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_hold_set: got %b want 1", err_sticky); end
        out_ready = 1'b1;
        repeat (10) tick();
        out_ready = 1'b0;
        n_tests++;
        if (acks != 3) begin n_fail++; $display("FAIL err_ignored: got %0d acks want 3", acks); end
        n_tests++;
        if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_sticky_hold: got %b want 1", err_sticky); end
        do_reset();
        n_tests++;
        if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", err_sticky); end
        send(8'h11);
        tick();
        req_tgl = ~req_tgl;
        repeat (6) tick();
        n_tests++;
        if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_consec_set: got %b want 1", err_sticky); end
        n_tests++;
        if (acks != 1) begin n_fail++; $display("FAIL err_consec_acks: got %0d want 1", acks); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_stream();
        test_clr_hold();
        test_release_high();
        test_random();
`ifdef TGL_HS_RX_ERR_EN
        test_err();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
